// File: rtl/uart_8250_rx_if.sv
// uart_8250_rx_if: register/bus front-end signals of the 8250 receive path
//   master: front end (drives DIVISOR_I, LCR_I, TRIG_I, FLUSH_I, RD_I, LSR_RD_I)
//   slave : receiver  (drives DATA_O, LEVEL_O, DR_O, OE_O, PE_O, FE_O, BI_O, TIMEOUT_O, INT_O)
interface uart_8250_rx_if;
  logic [15:0] DIVISOR_I;
  logic [7:0] LCR_I;
  logic [1:0] TRIG_I;
  logic FLUSH_I, RD_I, LSR_RD_I;
  logic [7:0] DATA_O, LEVEL_O;
  logic DR_O, OE_O, PE_O, FE_O, BI_O, TIMEOUT_O, INT_O;
  modport master (
    output DIVISOR_I, LCR_I, TRIG_I, FLUSH_I, RD_I, LSR_RD_I,
    input DATA_O, LEVEL_O, DR_O, OE_O, PE_O, FE_O, BI_O, TIMEOUT_O, INT_O
  );
  modport slave (
    input DIVISOR_I, LCR_I, TRIG_I, FLUSH_I, RD_I, LSR_RD_I,
    output DATA_O, LEVEL_O, DR_O, OE_O, PE_O, FE_O, BI_O, TIMEOUT_O, INT_O
  );
endinterface

// File: rtl/uart_8250_rx.sv
// uart_8250_rx: 16x-oversampled 8250 receiver with error-flagged RX FIFO and interrupt sources
//   CLK_I clock, RST_I async active-low reset, RX_I async serial input (idle high)
//   bus (slave): divisor/LCR/trigger/flush/read controls in; head data, flags, level, DR/OE, timeout, INT out
module uart_8250_rx #(
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT_TICKS = 640
) (
  input logic CLK_I,
  input logic RST_I,
  input logic RX_I,
  uart_8250_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nstate;
  logic rx_s1, rx_s2, tick, push, bi, pe, par_bit;
  logic [15:0] tick_cnt, div_m1;
  logic [3:0] smp;
  logic [2:0] bit_cnt;
  logic [7:0] data_q;
  logic [3:0] lcr_q;
  logic [10:0] push_word, head;
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, level;
  logic empty, full, do_pop, do_push, overrun, oe, irq;
  logic [TW-1:0] to_cnt;
  logic [7:0] trig_raw, trig_lvl;
  logic unused;
  assign unused = &{1'b0, bus.LCR_I[7:5], bus.LCR_I[2]};
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RX_I;
      rx_s2 <= rx_s1;
    end
  // >= rather than == so a divisor shrunk below the current count wraps at once
  assign div_m1 = (bus.DIVISOR_I == 16'd0) ? 16'd0 : bus.DIVISOR_I - 16'd1;
  assign tick = tick_cnt >= div_m1;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) tick_cnt <= '0;
    else tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) state <= IDLE;
    else state <= nstate;
  // lcr_q = {even, parity_en, wl[1:0]}; last data bit index is 4 + wl
  always_comb begin
    nstate = state;
    if (tick)
      case (state)
        IDLE: nstate = rx_s2 ? IDLE : START;
        START: nstate = smp != 4'd7 ? START : rx_s2 ? IDLE : DATA;
        DATA: nstate = (smp != 4'd15 || bit_cnt != {1'b1, lcr_q[1:0]}) ? DATA : lcr_q[2] ? PARITY : STOP;
        PARITY: nstate = smp == 4'd15 ? STOP : PARITY;
        STOP: nstate = smp == 4'd15 ? IDLE : STOP;
        default: nstate = IDLE;
      endcase
  end
  always_comb begin
    push = tick && state == STOP && smp == 4'd15;
    bi = data_q == 8'd0 && !par_bit && !rx_s2;
    pe = lcr_q[2] && ((^data_q ^ par_bit) == lcr_q[3]);
    push_word = {bi, !rx_s2, pe, data_q};
  end
  // sample counter wraps 15->0 naturally, giving one sample per bit after START re-centres it
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      smp <= '0;
      bit_cnt <= '0;
      data_q <= '0;
      par_bit <= 1'b0;
      lcr_q <= '0;
    end else if (tick) begin
      smp <= (state == IDLE || (state == START && smp == 4'd7)) ? 4'd0 : smp + 4'd1;
      if (state == START && smp == 4'd7) begin
        lcr_q <= {bus.LCR_I[4:3], bus.LCR_I[1:0]};
        data_q <= '0;
        par_bit <= 1'b0;
        bit_cnt <= '0;
      end
      if (state == DATA && smp == 4'd15) begin
        data_q[bit_cnt] <= rx_s2;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && smp == 4'd15) par_bit <= rx_s2;
    end
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign do_pop = bus.RD_I && !empty;
  assign do_push = push && (!full || do_pop);
  assign overrun = push && full && !do_pop;
  assign level = wp - rp;
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      wp <= '0;
      rp <= '0;
      oe <= 1'b0;
    end else if (bus.FLUSH_I) begin
      wp <= '0;
      rp <= '0;
      oe <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      oe <= overrun || (oe && !bus.LSR_RD_I);
    end
  always_ff @(posedge CLK_I)
    if (do_push && !bus.FLUSH_I) mem[wp[AW-1:0]] <= push_word;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) to_cnt <= '0;
    else if (push || do_pop || bus.FLUSH_I || empty) to_cnt <= '0;
    else if (tick && state == IDLE && to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
  assign trig_raw = bus.TRIG_I == 2'd0 ? 8'd1 : bus.TRIG_I == 2'd1 ? 8'd4 : bus.TRIG_I == 2'd2 ? 8'd8 : 8'd14;
  assign trig_lvl = trig_raw > 8'(FIFO_DEPTH) ? 8'(FIFO_DEPTH) : trig_raw;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) irq <= 1'b0;
    else irq <= (bus.LEVEL_O >= trig_lvl) || bus.TIMEOUT_O || oe || (bus.DR_O && (bus.PE_O || bus.FE_O || bus.BI_O));
  assign bus.DATA_O = empty ? 8'd0 : head[7:0];
  assign bus.PE_O = !empty && head[8];
  assign bus.FE_O = !empty && head[9];
  assign bus.BI_O = !empty && head[10];
  assign bus.LEVEL_O = 8'(level);
  assign bus.DR_O = !empty;
  assign bus.OE_O = oe;
  assign bus.TIMEOUT_O = to_cnt == TO_MAX;
  assign bus.INT_O = irq;
endmodule

// File: tb/tb_uart_8250_rx.sv
// tb_uart_8250_rx: directed scoreboard bench for uart_8250_rx
module tb_uart_8250_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] q[$];
  uart_8250_rx_if bus();
  uart_8250_rx #(.FIFO_DEPTH(32), .TIMEOUT_TICKS(640)) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .RX_I(rx),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // one frame, 16 clocks per bit (divisor 0/1); keep=1 queues the expected entry
  task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit pb, input bit stp, input bit keep);
    logic [7:0] m;
    int ones;
    bit perr;
    m = d & 8'((1 << nb) - 1);
    ones = $countones(m) + int'(pb);
    perr = pen && ((ones % 2 == 1) == bus.LCR_I[4]);
    if (keep) q.push_back({m == 8'd0 && !(pen && pb) && !stp, !stp, perr, m});
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      cyc(16);
    end
    if (pen) begin
      rx = pb;
      cyc(16);
    end
    rx = stp;
    cyc(16);
    rx = 1'b1;
  endtask
  task automatic rd_chk(input string tag);
    logic [10:0] e;
    e = q.size() != 0 ? q.pop_front() : 11'h7ff;
    chk({tag, ".dr"}, 32'(bus.DR_O), 32'd1);
    chk({tag, ".head"}, 32'({bus.BI_O, bus.FE_O, bus.PE_O, bus.DATA_O}), 32'(e));
    bus.RD_I = 1'b1;
    cyc(1);
    bus.RD_I = 1'b0;
  endtask
  initial begin
    bus.DIVISOR_I = 16'd1;
    bus.LCR_I = 8'h03;
    bus.TRIG_I = 2'd0;
    bus.FLUSH_I = 1'b0;
    bus.RD_I = 1'b0;
    bus.LSR_RD_I = 1'b0;
    cyc(3);
    chk("reset.outputs", 32'({bus.DATA_O, bus.LEVEL_O, bus.DR_O, bus.OE_O, bus.PE_O, bus.FE_O, bus.BI_O, bus.TIMEOUT_O, bus.INT_O}), 32'd0);
    rst_n = 1'b1;
    cyc(4);
    send(8'h55, 8, 0, 0, 1, 1);
    chk("8n1.level", 32'(bus.LEVEL_O), 32'd1);
    rd_chk("8n1");
    chk("8n1.level_after_rd", 32'(bus.LEVEL_O), 32'd0);
    chk("8n1.dr_after_rd", 32'(bus.DR_O), 32'd0);
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(40);
    chk("glitch.level", 32'(bus.LEVEL_O), 32'd0);
    bus.DIVISOR_I = 16'd0;
    bus.LCR_I = 8'h00;
    send(8'h1F, 5, 0, 0, 1, 1);
    rd_chk("5bit");
    bus.DIVISOR_I = 16'd1;
    bus.LCR_I = 8'h03;
    send(8'hA5, 8, 0, 0, 0, 1);
    cyc(32);
    rd_chk("framing");
    rx = 1'b0;
    cyc(160);
    rx = 1'b1;
    q.push_back({1'b1, 1'b1, 1'b0, 8'h00});
    cyc(32);
    chk("break.int", 32'(bus.INT_O), 32'd1);
    rd_chk("break");
    cyc(4);
    bus.LCR_I = 8'h1B;
    send(8'h01, 8, 1, 1, 1, 1);
    rd_chk("even_ok");
    send(8'h01, 8, 1, 0, 1, 1);
    rd_chk("even_bad");
    bus.LCR_I = 8'h03;
    for (int i = 0; i < 33; i++) send(8'($urandom_range(0, 255)), 8, 0, 0, 1, i < 32);
    chk("ovr.level", 32'(bus.LEVEL_O), 32'd32);
    chk("ovr.oe", 32'(bus.OE_O), 32'd1);
    chk("ovr.head", 32'(bus.DATA_O), 32'(q[0][7:0]));
    bus.LSR_RD_I = 1'b1;
    cyc(1);
    bus.LSR_RD_I = 1'b0;
    chk("lsr.oe_clear", 32'(bus.OE_O), 32'd0);
    chk("full.head", 32'({bus.BI_O, bus.FE_O, bus.PE_O, bus.DATA_O}), 32'(q[0]));
    void'(q.pop_front());
    fork
      send(8'h3C, 8, 0, 0, 1, 1);
      begin
        cyc(154);
        bus.RD_I = 1'b1;
        cyc(1);
        bus.RD_I = 1'b0;
      end
    join
    chk("full.rdpush_level", 32'(bus.LEVEL_O), 32'd32);
    chk("full.rdpush_oe", 32'(bus.OE_O), 32'd0);
    rd_chk("drain0");
    rd_chk("drain1");
    bus.FLUSH_I = 1'b1;
    cyc(1);
    bus.FLUSH_I = 1'b0;
    q.delete();
    chk("flush1.level", 32'(bus.LEVEL_O), 32'd0);
    bus.TRIG_I = 2'd1;
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 8, 0, 0, 1, 1);
    chk("trig3.int", 32'(bus.INT_O), 32'd0);
    chk("trig3.level", 32'(bus.LEVEL_O), 32'd3);
    cyc(600);
    chk("to.early", 32'(bus.TIMEOUT_O), 32'd0);
    for (int i = 0; i < 100 && !bus.TIMEOUT_O; i++) cyc(1);
    chk("to.set", 32'(bus.TIMEOUT_O), 32'd1);
    cyc(1);
    chk("to.int", 32'(bus.INT_O), 32'd1);
    send(8'h77, 8, 0, 0, 1, 1);
    chk("trig4.to_clear", 32'(bus.TIMEOUT_O), 32'd0);
    chk("trig4.int", 32'(bus.INT_O), 32'd1);
    chk("trig4.head", 32'({bus.BI_O, bus.FE_O, bus.PE_O, bus.DATA_O}), 32'(q[0]));
    bus.FLUSH_I = 1'b1;
    cyc(1);
    bus.FLUSH_I = 1'b0;
    q.delete();
    cyc(1);
    chk("flush2.level", 32'(bus.LEVEL_O), 32'd0);
    chk("flush2.int", 32'(bus.INT_O), 32'd0);
    chk("flush2.dr", 32'(bus.DR_O), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
